arbitrated_ram: RTL and testbench
=================================

# arbitrated_ram

Parametrised multi-requester single-port RAM. PORTS independent requesters share one memory array through a round-robin arbiter with valid/ready handshakes. Writes support byte enables, and reads return on a registered, one-cycle-latency response channel per port. It is the successor to the team's single-requester asynchronous-read RAM and serves as the shared data memory between the CPU core and DMA/video masters.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH
- ADDR_SPACE, 16, address width; depth = 2^ADDR_SPACE words
- PORTS, 2, number of requesters (1..8)
- BYTE_WIDTH, 8, bits per byte-enable lane; BYTES = DATA_WIDTH/BYTE_WIDTH

- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  PORTS  request present, one bit per port
- req_ready  out  PORTS  grant; request accepted on the edge where valid&ready
- req_wren  in  PORTS  1 = write, 0 = read
- req_address  in  PORTS*ADDR_SPACE  word address, port p at slice [p*ADDR_SPACE +: ADDR_SPACE]
- req_data  in  PORTS*DATA_WIDTH  write data per port
- req_byteen  in  PORTS*BYTES  write byte enables per port; ignored for reads
- rsp_valid  out  PORTS  one-cycle pulse, read data valid for that port
- rsp_q  out  PORTS*DATA_WIDTH  read data per port, held between responses

## Operation
- Exactly one memory access per cycle.
- Arbiter: round-robin over ports with req_valid=1. Search starts at pointer `ptr`.
- At most one req_ready bit is high. It is set only for the winning port, combinationally from req_valid and ptr. No ready is given to an idle port.
- On acceptance of port g, ptr becomes (g+1) mod PORTS. With no acceptance, ptr holds.
- Write accept: at that edge, for each lane b with req_byteen[g*BYTES+b]=1, memory[addr] lane b ← req_data lane b. Other lanes are unchanged. No response is generated.
- Read accept: memory is read at the accept edge. On the next cycle rsp_valid[g]=1 and rsp_q slice g = word value before any write in the accept cycle (no write can coincide, since there is one access per cycle).
- rsp_q of a port changes only on its own read response. It otherwise holds its last value.
- A requester may hold req_valid with changing payload until it sees ready. Payload is sampled only at the accept edge.
- Reset:
  - ptr=0, rsp_valid=0, all rsp_q=0.
  - req_ready is forced to 0 while reset=1, so no accesses happen during reset.
  - A read accepted in the cycle before reset rises produces no rsp_valid (response dropped).
  - Memory contents are not reset.
- PORTS=1 degenerates to ready=valid, with no fairness state.

## Timing
- Write: data visible to a read accepted on the following cycle.
- Read latency: 1 cycle from accept edge to rsp_valid/rsp_q.
- Throughput: 1 access/cycle total. Under contention each of k active ports is served once every k cycles.
- Worst-case wait for a continuously valid port: PORTS-1 cycles.
- req_ready is combinational from req_valid. Requesters must not make req_valid depend on req_ready.

## Structure
- Package arbitrated_ram_pkg: function returning BYTES, clog2 helper for ptr width, and per-port slice index helpers.
- Sub-module rr_arbiter (PORTS parameter):
  - Inputs: clock, reset, request vector, advance strobe.
  - Outputs: one-hot grant and grant index.
  - Holds ptr.
- Top level holds the memory array, the write-enable lane mask, the registered read data and the response demux.

## Test plan
- Reset then single port: port0 writes 0xBEEF to addr 0x0010 with byteen=11, then reads addr 0x0010 → rsp_valid[0] exactly 1 cycle after accept, rsp_q[0]=0xBEEF; rsp_valid[1] stays 0.
- Byte enables: write 0x1234 to addr 5, then write 0xAB00 with byteen=10, then read addr 5 → 0xAB34.
- Contention: ports 0 and 1 both hold valid reads for 6 cycles from reset → grants alternate 0,1,0,1,0,1. Each port sees 3 responses, each 1 cycle after its own grant.
- Fairness, PORTS=4: all four valid continuously → grant sequence 0,1,2,3,0. Drop port 2's valid → sequence skips 2 with no idle cycle.
- Reset mid-operation: port1 read accepted, reset asserted next cycle → no rsp_valid[1]; after release rsp_q=0, ptr=0, and the first grant with both ports valid goes to port0.
- Hold behaviour: after a response of 0x00FF on port0, port1 reads 0x1111 → rsp_q[0] stays 0x00FF and req_ready never has two bits set.

Source files
------------

// File: rtl/arbitrated_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arbitrated_ram_pkg
// Description : Shared sizing helpers for the arbitrated multi-requester RAM.
//               Provides the byte-lane count, the round-robin pointer width
//               and the per-port slice offsets used to address the flat
//               request/response buses.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package arbitrated_ram_pkg;

  // Number of byte-enable lanes in one word.
  function automatic int bytes_of(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  // Pointer/index width for n requesters; never narrower than one bit so a
  // single-port build still has a legal vector type.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low bit of port p's address slice.
  function automatic int addr_lo(input int p, input int addr_space);
    return p * addr_space;
  endfunction

  // Low bit of port p's data slice (write data and read data alike).
  function automatic int data_lo(input int p, input int data_width);
    return p * data_width;
  endfunction

  // Low bit of port p's byte-enable slice.
  function automatic int be_lo(input int p, input int bytes);
    return p * bytes;
  endfunction

endpackage : arbitrated_ram_pkg
`default_nettype wire

// File: rtl/arbitrated_ram_if.sv
`default_nettype none
// ============================================================================
// Module      : arbitrated_ram_if
// Description : Request/response bundle shared by all requesters of the
//               arbitrated RAM. Every field is a flat vector with one slice
//               per port (port p at [p*W +: W]).
// Signals     : req_valid/req_ready  - per-port handshake
//               req_wren             - 1 = write, 0 = read
//               req_address          - word address per port
//               req_data/req_byteen  - write payload and lane enables
//               rsp_valid/rsp_q      - one-cycle read response per port
// Modports    : master (requesters), slave (RAM)
// Revision    : 1.0 - initial release
// ============================================================================
interface arbitrated_ram_if
  import arbitrated_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SPACE = 16,
  parameter int PORTS      = 2,
  parameter int BYTE_WIDTH = 8
);

  localparam int BYTES = bytes_of(DATA_WIDTH, BYTE_WIDTH);

  logic [PORTS-1:0]            req_valid;
  logic [PORTS-1:0]            req_ready;
  logic [PORTS-1:0]            req_wren;
  logic [PORTS*ADDR_SPACE-1:0] req_address;
  logic [PORTS*DATA_WIDTH-1:0] req_data;
  logic [PORTS*BYTES-1:0]      req_byteen;
  logic [PORTS-1:0]            rsp_valid;
  logic [PORTS*DATA_WIDTH-1:0] rsp_q;

  modport master (
    output req_valid, req_wren, req_address, req_data, req_byteen,
    input  req_ready, rsp_valid, rsp_q
  );

  modport slave (
    input  req_valid, req_wren, req_address, req_data, req_byteen,
    output req_ready, rsp_valid, rsp_q
  );

endinterface : arbitrated_ram_if
`default_nettype wire

// File: rtl/arbitrated_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. The search for a valid requester starts
//               at ptr_q; the first valid port found wins. The grant is purely
//               combinational from req_i and ptr_q and is forced low during
//               reset. On an advance strobe ptr_q moves one past the winner.
// Ports       : clk_i      - clock
//               rst_i      - synchronous active-high reset
//               req_i      - request vector, one bit per port
//               adv_i      - winner was accepted this cycle
//               gnt_o      - one-hot grant (all zero when idle or in reset)
//               gnt_idx_o  - index of the granted port
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import arbitrated_ram_pkg::*;
#(
  parameter  int PORTS = 2,
  localparam int PW    = ptr_width(PORTS)
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic [PORTS-1:0] req_i,
  input  wire logic             adv_i,
  output logic      [PORTS-1:0] gnt_o,
  output logic      [PW-1:0]    gnt_idx_o
);

  if (PORTS == 1) begin : g_single
    // A lone requester is always the winner; there is no fairness state.
    logic w_unused;
    assign w_unused  = &{1'b0, clk_i, adv_i};
    assign gnt_o     = req_i & {PORTS{~rst_i}};
    assign gnt_idx_o = '0;
  end else begin : g_rr
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          w_found;

    always_comb begin
      int j;
      j         = 0;
      w_found   = 1'b0;
      gnt_o     = '0;
      gnt_idx_o = '0;
      // Rotate the search by ptr_q; the wrap keeps j inside 0..PORTS-1 even
      // when PORTS is not a power of two.
      for (int i = 0; i < PORTS; i++) begin
        j = int'(ptr_q) + i;
        if (j >= PORTS) begin
          j = j - PORTS;
        end
        if (!w_found && req_i[j]) begin
          w_found   = 1'b1;
          gnt_o[j]  = 1'b1;
          gnt_idx_o = PW'(j);
        end
      end
      if (rst_i) begin
        gnt_o = '0;
      end
    end

    assign ptr_d = (gnt_idx_o == PW'(PORTS - 1)) ? '0 : gnt_idx_o + PW'(1);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        ptr_q <= '0;
      end else if (adv_i) begin
        ptr_q <= ptr_d;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arbitrated_ram.sv
`default_nettype none
// ============================================================================
// Module      : arbitrated_ram
// Description : Single-port RAM shared by PORTS requesters through a
//               round-robin arbiter. One access per cycle; writes honour
//               per-lane byte enables; reads answer one cycle after the
//               accept edge on the requesting port's response slice, which
//               otherwise holds its last read value.
// Ports       : clk_i  - clock, all logic on the rising edge
//               rst_i  - synchronous active-high reset
//               bus    - arbitrated_ram_if slave modport (requests/responses)
// Revision    : 1.0 - initial release
// ============================================================================
module arbitrated_ram
  import arbitrated_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SPACE = 16,
  parameter int PORTS      = 2,
  parameter int BYTE_WIDTH = 8
) (
  input wire logic         clk_i,
  input wire logic         rst_i,
  arbitrated_ram_if.slave  bus
);

  localparam int BYTES = bytes_of(DATA_WIDTH, BYTE_WIDTH);
  localparam int PW    = ptr_width(PORTS);
  localparam int DEPTH = 2 ** ADDR_SPACE;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [PORTS-1:0] w_gnt;
  logic [PW-1:0]    w_gnt_idx;
  logic             w_accept;

  // The grant is already a subset of req_valid, so any grant bit is an accept.
  assign w_accept      = |(bus.req_valid & w_gnt);
  assign bus.req_ready = w_gnt;

  rr_arbiter #(
    .PORTS (PORTS)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (bus.req_valid),
    .adv_i     (w_accept),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx)
  );

  // --------------------------------------------------------------------------
  // Payload selection from the winning port (one-hot mux)
  // --------------------------------------------------------------------------
  logic [ADDR_SPACE-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BYTES-1:0]      w_be;
  logic                  w_wren;
  logic [BYTES-1:0]      w_lane_we;
  logic                  w_rd;

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_be    = '0;
    w_wren  = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (w_gnt[p]) begin
        w_addr  = bus.req_address[addr_lo(p, ADDR_SPACE) +: ADDR_SPACE];
        w_wdata = bus.req_data[data_lo(p, DATA_WIDTH) +: DATA_WIDTH];
        w_be    = bus.req_byteen[be_lo(p, BYTES) +: BYTES];
        w_wren  = bus.req_wren[p];
      end
    end
  end

  assign w_lane_we = w_be & {BYTES{w_accept & w_wren}};
  assign w_rd      = w_accept & ~w_wren;

  // --------------------------------------------------------------------------
  // Memory array and registered read data (contents are never reset)
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BYTES; b++) begin
      if (w_lane_we[b]) begin
        mem_q[w_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= w_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    if (w_rd) begin
      rd_data_q <= mem_q[w_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Response demux
  // --------------------------------------------------------------------------
  logic                            rd_valid_q;
  logic [PW-1:0]                   rd_port_q;
  logic [PORTS-1:0][DATA_WIDTH-1:0] hold_q;
  logic [PORTS-1:0]                w_fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_q <= 1'b0;
      rd_port_q  <= '0;
      hold_q     <= '0;
    end else begin
      rd_valid_q <= w_rd;
      if (w_rd) begin
        rd_port_q <= w_gnt_idx;
      end
      for (int p = 0; p < PORTS; p++) begin
        if (w_fire[p]) begin
          hold_q[p] <= rd_data_q;
        end
      end
    end
  end

  // A response still in flight when reset rises is suppressed here, so the
  // port neither sees rsp_valid nor a change of rsp_q before hold_q clears.
  for (genvar p = 0; p < PORTS; p++) begin : g_rsp
    assign w_fire[p] = rd_valid_q & (rd_port_q == PW'(p)) & ~rst_i;
    assign bus.rsp_valid[p] = w_fire[p];
    assign bus.rsp_q[p*DATA_WIDTH +: DATA_WIDTH] = w_fire[p] ? rd_data_q : hold_q[p];
  end

endmodule : arbitrated_ram
`default_nettype wire

// File: tb/tb_arbitrated_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitrated_ram
// Description : Self-checking bench for arbitrated_ram. A two-port instance
//               is tracked by a scoreboard (reference memory plus per-port
//               queues of expected read responses); a four-port instance
//               exercises round-robin fairness.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitrated_ram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arbitrated_ram_if #(.DATA_WIDTH(16), .ADDR_SPACE(16), .PORTS(2), .BYTE_WIDTH(8)) ifa ();
  arbitrated_ram_if #(.DATA_WIDTH(16), .ADDR_SPACE(16), .PORTS(4), .BYTE_WIDTH(8)) ifb ();

  arbitrated_ram #(.DATA_WIDTH(16), .ADDR_SPACE(16), .PORTS(2), .BYTE_WIDTH(8)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  arbitrated_ram #(.DATA_WIDTH(16), .ADDR_SPACE(16), .PORTS(4), .BYTE_WIDTH(8)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q [2][$];
  logic [15:0] mem_m [int];
  logic [15:0] rspq_m [2];
  int          rsp_cnt [2];
  int          log_a [$];
  int          log_b [$];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the two-port instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      check_eq("a_ready_in_reset", ifa.req_ready, 32'h0);
      check_eq("a_rsp_valid_in_reset", ifa.rsp_valid, 32'h0);
      for (int p = 0; p < 2; p++) begin
        exp_q[p].delete();
        rspq_m[p] = 16'h0;
      end
    end else begin
      check_eq("a_ready_onehot", ($countones(ifa.req_ready) <= 1), 32'h1);
      check_eq("a_ready_idle_port", ifa.req_ready & ~ifa.req_valid, 32'h0);
      for (int p = 0; p < 2; p++) begin
        bit exp_v;
        exp_v = (exp_q[p].size() > 0) && (exp_q[p][0].due <= cyc);
        check_eq($sformatf("a_rsp_valid_p%0d", p), ifa.rsp_valid[p], exp_v);
        if (ifa.rsp_valid[p]) rsp_cnt[p]++;
        if (exp_v) begin
          rspq_m[p] = exp_q[p][0].data;
          exp_q[p].pop_front();
        end
        check_eq($sformatf("a_rsp_q_p%0d", p), ifa.rsp_q[p*16 +: 16], rspq_m[p]);
      end
      for (int p = 0; p < 2; p++) begin
        if (ifa.req_valid[p] && ifa.req_ready[p]) begin
          int          a;
          logic [15:0] w;
          exp_t        e;
          a = int'(ifa.req_address[p*16 +: 16]);
          w = mem_m.exists(a) ? mem_m[a] : 16'h0;
          log_a.push_back(p);
          if (ifa.req_wren[p]) begin
            for (int b = 0; b < 2; b++) begin
              if (ifa.req_byteen[p*2 + b]) w[b*8 +: 8] = ifa.req_data[p*16 + b*8 +: 8];
            end
            mem_m[a] = w;
          end else begin
            e.due  = cyc + 1;
            e.data = w;
            exp_q[p].push_back(e);
          end
        end
      end
    end
  end

  // Grant log for the four-port instance.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("b_ready_onehot", ($countones(ifb.req_ready) <= 1), 32'h1);
      for (int p = 0; p < 4; p++) begin
        if (ifb.req_valid[p] && ifb.req_ready[p]) log_b.push_back(p);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one request on port p of the two-port instance and hold it until
  // the accept edge; returns #1 after that edge.
  task automatic issue(input int p, input bit wr, input logic [15:0] addr,
                       input logic [15:0] data, input logic [1:0] be);
    int n;
    bit got;
    ifa.req_valid[p]             = 1'b1;
    ifa.req_wren[p]              = wr;
    ifa.req_address[p*16 +: 16]  = addr;
    ifa.req_data[p*16 +: 16]     = data;
    ifa.req_byteen[p*2 +: 2]     = be;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (ifa.req_ready[p]) got = 1'b1;
      else n++;
    end
    check_eq($sformatf("issue_accept_p%0d", p), got, 32'h1);
    @(posedge clk);
    #1;
    ifa.req_valid[p] = 1'b0;
  endtask

  int exp_b [11] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3, 0};
  int base0, base1;

  initial begin
    ifa.req_valid = '0; ifa.req_wren = '0; ifa.req_address = '0;
    ifa.req_data  = '0; ifa.req_byteen = '0;
    ifb.req_valid = '0; ifb.req_wren = '0; ifb.req_address = '0;
    ifb.req_data  = '0; ifb.req_byteen = '0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_rsp_q", ifa.rsp_q, 32'h0);
    check_eq("reset_rsp_valid", ifa.rsp_valid, 32'h0);
    idle(1);

    // Single port write then read back.
    issue(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11);
    issue(0, 1'b0, 16'h0010, 16'h0000, 2'b00);
    @(negedge clk);
    check_eq("single_rsp_valid", ifa.rsp_valid, 32'h1);
    check_eq("single_rsp_q", ifa.rsp_q[15:0], 32'hBEEF);
    idle(1);

    // Byte-enable merge.
    issue(0, 1'b1, 16'h0005, 16'h1234, 2'b11);
    issue(0, 1'b1, 16'h0005, 16'hAB00, 2'b10);
    issue(0, 1'b0, 16'h0005, 16'h0000, 2'b00);
    @(negedge clk);
    check_eq("byteen_merge", ifa.rsp_q[15:0], 32'hAB34);
    idle(1);

    // Response hold across the other port's read.
    issue(0, 1'b1, 16'h0007, 16'h00FF, 2'b11);
    issue(1, 1'b1, 16'h0008, 16'h1111, 2'b11);
    issue(0, 1'b0, 16'h0007, 16'h0000, 2'b00);
    issue(1, 1'b0, 16'h0008, 16'h0000, 2'b00);
    @(negedge clk);
    check_eq("hold_p1", ifa.rsp_q[31:16], 32'h1111);
    check_eq("hold_p0", ifa.rsp_q[15:0], 32'h00FF);
    idle(1);

    // Contention from reset: both ports read continuously for six cycles.
    issue(0, 1'b1, 16'h0020, 16'hA0A0, 2'b11);
    issue(1, 1'b1, 16'h0021, 16'h5151, 2'b11);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    log_a.delete();
    base0 = rsp_cnt[0];
    base1 = rsp_cnt[1];
    ifa.req_wren = 2'b00;
    ifa.req_address = {16'h0021, 16'h0020};
    ifa.req_valid = 2'b11;
    idle(6);
    ifa.req_valid = 2'b00;
    idle(2);
    check_eq("cont_grant_count", log_a.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      int g;
      g = (i < log_a.size()) ? log_a[i] : -1;
      check_eq($sformatf("cont_grant%0d", i), g, i % 2);
    end
    check_eq("cont_rsp_cnt0", rsp_cnt[0] - base0, 32'd3);
    check_eq("cont_rsp_cnt1", rsp_cnt[1] - base1, 32'd3);

    // Reset right after a port-1 read accept: that response must vanish.
    issue(1, 1'b0, 16'h0021, 16'h0000, 2'b00);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    log_a.delete();
    ifa.req_wren = 2'b00;
    ifa.req_address = {16'h0021, 16'h0020};
    ifa.req_valid = 2'b11;
    @(negedge clk);
    check_eq("mid_rst_rsp_q", ifa.rsp_q, 32'h0);
    check_eq("mid_rst_first_grant", ifa.req_ready, 32'h1);
    idle(1);
    @(negedge clk);
    check_eq("mid_rst_second_grant", ifa.req_ready, 32'h2);
    idle(1);
    ifa.req_valid = 2'b00;
    idle(2);

    // Four-port fairness, then drop port 2 mid-stream.
    log_b.delete();
    ifb.req_wren    = '0;
    ifb.req_address = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    ifb.req_valid   = 4'b1111;
    idle(5);
    ifb.req_valid[2] = 1'b0;
    idle(6);
    ifb.req_valid = 4'b0000;
    idle(2);
    check_eq("fair_grant_count", log_b.size(), 32'd11);
    for (int i = 0; i < 11; i++) begin
      int g;
      g = (i < log_b.size()) ? log_b[i] : -1;
      check_eq($sformatf("fair_grant%0d", i), g, exp_b[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_arbitrated_ram
`default_nettype wire
